guess_button_conditioner: RTL
=============================

Name: guess_button_conditioner

Overview:
- Upstream front end for the guess counter.
- Takes the raw, asynchronous, bouncing active-low guess pushbutton and synchronises and debounces it.
- Drives a clean active-low Guess_button level that produces exactly one falling edge per accepted press, plus a one-cycle Guess_pulse strobe for clocked consumers.
- Gates new presses with Enable, so presses made while the game is inactive are swallowed.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a press or a release (10 ms at 50 MHz); legal minimum 2.
- CNT_WIDTH, 19, width of the debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Key_n  in  1  raw pushbutton, active-low, asynchronous to Clock, may bounce.
- Enable  in  1  game active; when 0, newly accepted presses produce no output.
- Guess_button  out  1  debounced active-low level for the guess counter; 1 = released.
- Guess_pulse  out  1  one-cycle high strobe coincident with each falling edge of Guess_button.
- Busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Synchroniser:
  - Key_n passes through 2 flops to give k_s; both flops reset to 1.
  - Only k_s is used downstream.
- Outputs are all registered.
  - Reset values: Guess_button=1, Guess_pulse=0, Busy=0.
  - Internal reset values: FSM=IDLE, counter=0, synchroniser=1.
- FSM states and transitions:
  - IDLE:
    - If k_s=0, go to PRESS_WAIT with cnt=1.
    - Otherwise stay.
  - PRESS_WAIT:
    - If k_s=1, go to IDLE with cnt=0 (glitch rejected, no output).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED (accept).
    - Else cnt+1.
  - Accept action:
    - If Enable=1 on the accepting edge, Guess_button goes 0 and Guess_pulse goes 1 for exactly that one cycle.
    - If Enable=0, the press is consumed silently: Guess_button stays 1, no pulse, but the FSM still enters PRESSED.
  - PRESSED:
    - Hold outputs.
    - If k_s=1, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - If k_s=0, go back to PRESSED with cnt=0 (release bounce ignored, no new pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE and set Guess_button to 1.
    - Else cnt+1.
- Latency:
  - A press is accepted on the edge that samples the DEBOUNCE_CYCLES-th consecutive k_s=0.
  - From raw Key_n falling to Guess_pulse: DEBOUNCE_CYCLES+2 edges, +1 edge for input phase.
  - Release is handled symmetrically.
- Guess_pulse is never high for 2 consecutive cycles.
  - Minimum spacing between pulses is 2*DEBOUNCE_CYCLES cycles.
- Enable changes:
  - An Enable change during PRESSED or RELEASE_WAIT does not alter Guess_button.
  - A level already driven low stays low until the debounced release.
- Counter never wraps.
  - It is bounded by DEBOUNCE_CYCLES-1 and cleared on every state exit.
- Reset mid-operation (any state):
  - Next edge gives IDLE with all outputs at reset values.
  - Guess_button may rise without a debounced release.
  - If Key_n is still held low after Reset deasserts, the synchroniser refills and the FSM re-debounces it as a new press. That press is accepted if Enable=1.
- Reset has priority over all other inputs on the same edge.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: Key_n 1→0, held 20 cycles then released, Enable=1 → exactly one Guess_pulse, 6±1 edges after the fall. Guess_button goes 0 on the same edge and returns to 1 about 6 edges after the release. Busy is high throughout.
- Bounce rejection: Key_n pulsed low for 2, 1, then 3 cycles with high gaps of 1 cycle, then held high → no pulse, Guess_button stays 1, FSM returns to IDLE. Then held low for 10 cycles → exactly one pulse.
- Release bounce: while PRESSED, Key_n toggles high 2 cycles / low 1 cycle ×3 → Guess_button stays 0 and no extra pulse. A clean release of ≥4 cycles then returns it to 1.
- Enable gating: Enable=0 during the accept edge of a full press → no pulse and Guess_button stays 1. Enable raised while still pressed → still no pulse. The next full press with Enable=1 produces one pulse.
- Ten back-to-back clean presses with Enable=1 → 10 pulses, 10 falling edges on Guess_button, no pulse adjacency.
- Reset mid-press: assert Reset for 1 cycle while PRESSED with Key_n held low → next edge gives Guess_button=1, Busy=0. With Key_n still low and Enable=1, a new pulse follows 6±1 edges after Reset deasserts.

Source files
------------

// File: rtl/guess_button_conditioner.sv
// Synchronises and debounces the active-low guess pushbutton, producing a clean
// active-low level plus a one-cycle strobe per accepted press, gated by enable.
module guess_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_key_n,
    input  logic i_enable,
    output logic o_guess_button,
    output logic o_guess_pulse,
    output logic o_busy
);

    // state        | meaning
    // IDLE         | released, waiting for first low sample
    // PRESS_WAIT   | counting consecutive low samples
    // PRESSED      | press accepted (or swallowed), waiting for first high sample
    // RELEASE_WAIT | counting consecutive high samples
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_button;
    logic                 r_pulse;
    logic                 r_busy;

    logic w_ks;
    assign w_ks = r_sync2;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= CNT_ZERO;
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_button <= 1'b1;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_ks) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (w_ks) begin
                        r_state <= IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        // A press seen while disabled is still tracked so its release is debounced.
                        r_state <= PRESSED;
                        r_cnt   <= CNT_ZERO;
                        if (i_enable) begin
                            r_button <= 1'b0;
                            r_pulse  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_ks) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (!w_ks) begin
                        r_state <= PRESSED;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state  <= IDLE;
                        r_cnt    <= CNT_ZERO;
                        r_button <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_guess_button = r_button;
    assign o_guess_pulse  = r_pulse;
    assign o_busy         = r_busy;

endmodule
